// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the pipeline-stage register and its skid buffer.
package pipe_stage_reg_pkg;

    localparam int XLEN = 64;

    // Occupancy of the main register; out_valid is simply "state is FULL".
    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// pipe_skid_buf: one-entry skid register plus its valid bit.
// Only compiled into the design when PIPE_SKID_BUF_EN is defined.
`ifdef PIPE_SKID_BUF_EN
module pipe_skid_buf #(
    parameter int               WIDTH     = pipe_stage_reg_pkg::XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, back-pressure and flush.
// Define PIPE_SKID_BUF_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = (state_q == STAGE_FULL);
    assign out_data  = data_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_SKID_BUF_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_load;

    // Gated by rst only; the ready path never sees out_ready combinationally.
    assign in_ready  = rst & ~skid_valid;
    assign skid_load = in_xfer & out_valid & ~out_ready & ~flush;

    pipe_skid_buf #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush),
        .load_i  (skid_load),
        .drain_i (out_xfer),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = STAGE_EMPTY;
        end else if (skid_valid) begin
            // in_ready is low here, so the only possible move is skid -> main.
            if (out_xfer) begin
                state_d = STAGE_FULL;
                data_d  = skid_data;
            end
        end else if (in_xfer && (!out_valid || out_ready)) begin
            state_d = STAGE_FULL;
            data_d  = in_data;
        end else if (out_xfer) begin
            state_d = STAGE_EMPTY;
        end
    end
`else
    assign in_ready = rst & (~out_valid | out_ready);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = STAGE_EMPTY;
        end else if (in_xfer) begin
            state_d = STAGE_FULL;
            data_d  = in_data;
        end else if (out_xfer) begin
            state_d = STAGE_EMPTY;
        end
    end
`endif

    // NOTE: state uses non-blocking assignments; payload keeps its value on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STAGE_EMPTY;
            data_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue model of stage occupancy.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] mq[$];
    bit          accepted;

    pipe_stage_reg #(
        .WIDTH     (64),
        .RESET_VAL (64'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the queue, then advance the queue by the
    // transfers the handshake rules allow at the coming edge.
    task automatic cycle();
        bit          exp_ready, in_x, out_x, fl;
        logic [63:0] d;
        #1;
        exp_ready = SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
        check("out_valid", out_valid, 64'(mq.size() > 0));
        check("in_ready", in_ready, 64'(exp_ready));
        if (mq.size() > 0) check("out_data", out_data, mq[0]);
        in_x  = in_valid && exp_ready;
        out_x = (mq.size() > 0) && out_ready;
        fl    = flush;
        d     = in_data;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(d);
        end
        accepted = in_x && !fl;
    endtask

    initial begin
        logic [63:0] offers[2];
        int          idx;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_in_ready", in_ready, 64'd1);
        check("release_out_valid", out_valid, 64'd0);

        // Full-rate stream 0x1..0x8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Stall with 0xA held, offering 0xB then 0xC
        offers[0] = 64'hB;
        offers[1] = 64'hC;
        idx       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        cycle();
        for (int k = 0; k < 3; k++) begin
            in_valid = (idx < 2);
            in_data  = offers[(idx < 2) ? idx : 1];
            cycle();
            check("stall_hold_a", out_data, 64'hA);
            if (accepted) idx++;
        end
        check("stall_skid_took", 64'(idx), SKID ? 64'd1 : 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = (idx < 2);
            in_data  = offers[(idx < 2) ? idx : 1];
            cycle();
            if (accepted) idx++;
        end
        check("stall_all_offered", 64'(idx), 64'd2);

        // Flush a full stage while a new payload is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        cycle();
        in_data = 64'h6;
        cycle();
        flush   = 1'b1;
        in_data = 64'h7;
        cycle();
        check("flush_empty", out_valid, 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h9;
        cycle();
        check("pre_async_full", out_valid, 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_out_valid", out_valid, 64'd0);
        check("async_out_data", out_data, 64'd0);
        check("async_in_ready", in_ready, 64'd0);
        mq.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rerelease_in_ready", in_ready, 64'd1);

        // Random traffic against the queue model
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = {$urandom, $urandom};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline-stage register with a valid/ready handshake, back-pressure and flush. It is the successor to the fixed, always-enabled IF/ID, ID/EX, EX/MEM and MEM/WB field registers. One instance sits between two adjacent pipeline stages and carries a packed payload bus, so stalls and branch/trap flushes are handled in one place instead of per field.

## Interface
- `WIDTH`, default `` `XLEN ``: payload width in bits, ≥1.
- `RESET_VAL`, default `{WIDTH{1'b0}}`: payload value after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert supplied externally.
- `flush`  in  1  kill every payload held in the stage (branch mispredict / trap).
- `in_valid`  in  1  upstream stage presents a payload.
- `in_ready`  out  1  stage can accept the payload this cycle.
- `in_data`  in  WIDTH  upstream payload (packed pc/inst/op fields).
- `out_valid`  out  1  stage holds a live payload.
- `out_ready`  in  1  downstream stage consumes the payload this cycle.
- `out_data`  out  WIDTH  held payload.

## Operation
- Transfer in: `in_valid & in_ready` at a clock edge. Transfer out: `out_valid & out_ready` at a clock edge.
- Main register states: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY + in-transfer → FULL, `out_data<=in_data`.
  - FULL + out-transfer + in-transfer → FULL with the new data, for full throughput.
  - FULL + out-transfer, no in-transfer → EMPTY. `out_data` holds its last value.
  - FULL + `out_ready=0` → FULL. `out_data` is stable and must not change while stalled.
- Without the skid buffer: `in_ready = ~out_valid | out_ready`, which is combinational from `out_ready`.
- Flush has priority over everything. At the edge where `flush=1`, all valid bits clear and any in-transfer in that cycle is discarded. Payload registers are not cleared.
- `in_ready` is 0 while `rst` is low, in both configurations.
- The payload of an invalid stage is don't-care downstream. The verifier checks `out_data` only when `out_valid=1`, except for the reset value.

## Timing
- Reset values: `out_valid=0`, `out_data=RESET_VAL`, skid valid 0, skid data `RESET_VAL`. `in_ready` is 0 during reset and 1 in the first cycle after deassertion.
- Latency: 1 cycle from in-transfer to `out_valid`/`out_data` visible.
- Throughput: 1 transfer per cycle when `out_ready` is held at 1.
- A simultaneous in- and out-transfer in the FULL state leaves the stage FULL with the new payload and loses no bubble.
- Flush in the cycle after a stall resumes: the stage is EMPTY on the next cycle, and `in_ready=1` in the cycle following the flush edge.
- Reset mid-transfer: the stage goes EMPTY immediately and asynchronously, and `out_valid` drops without waiting for a clock edge.

## Configuration
- Macro `PIPE_SKID_BUF_EN`.
- Defined:
  - A one-entry skid register is added behind the main register.
  - `in_ready = ~skid_valid` and is driven from a flop, with no combinational path from `out_ready`.
  - A payload accepted while the main register is FULL and not draining goes into the skid register.
  - When the main register drains, the skid entry moves into it in the same edge. Order is preserved: skid data always precedes new input.
  - Capacity is 2 and throughput stays 1 per cycle. Flush clears both valids.
- Undefined: single register with combinational `in_ready` as described in Operation. No skid logic is synthesised.

## Structure
- Shared constants (`XLEN`, per-stage payload widths such as `ID_EX_PAYLOAD_LEN`) go in the existing `sysconfig.v` header. Stages pack their fields into one bus using these widths.
- One sub-module, `pipe_skid_buf`, holds the skid entry plus its valid. It is instantiated only under `PIPE_SKID_BUF_EN`.
- Flops are written locally with async active-low reset. `regTemplate` is not reused, because its reset style differs.

## Test plan
- Reset, then release with `WIDTH=64` and `RESET_VAL=0` → `out_valid=0`, `out_data=0`, `in_ready=0` during reset, `in_ready=1` on the first cycle after release.
- Stream 0x1..0x8 with `in_valid=1` and `out_ready=1` every cycle → `out_data` shows 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance, with no gaps.
- Accept 0xA, hold `out_ready=0` for 3 cycles while offering 0xB, 0xC → `out_data=0xA` stable.
  - Skid off: `in_ready=0` after 0xA is taken.
  - Skid on: 0xB is accepted, then `in_ready=0`.
  - Release `out_ready` → 0xA then 0xB (then 0xC) in order, none lost or duplicated.
- Stage FULL with 0x5 (and skid holding 0x6 when skid is on); `flush=1` with `in_valid=1`, `in_data=0x7` → next cycle `out_valid=0`, and 0x5, 0x6, 0x7 never appear.
- Assert `rst=0` between edges while FULL → `out_valid` falls immediately and `out_data=RESET_VAL`.
- Random `in_valid`/`out_ready`/`flush` for 10k cycles against a queue model → output order matches, and no transfer occurs when `out_valid=0`.
